packet_header_parser: RTL and testbench

//   Turns a byte stream of 5-tuple headers into packet_s words for the rule_match array.

---
 rtl/packet_header_parser.sv | 142 ++++++++++++++
 tb/tb_packet_header_parser.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_header_parser.sv
// packet_header_parser
//   Assembles 13-byte 5-tuple headers from an ingress byte stream into
//   packet_s words for the classifier. Frames that are not exactly
//   HDR_BYTES long are dropped, flagged on err_pulse and counted.
//   A separate shift register collects the next header while the previous
//   one waits in the out_packet holding register.
// Ports
//   clk, rst_n            clock, async active-low reset
//   in_data/valid/last    byte stream in; in_ready back-pressure out
//   out_packet/valid      assembled header; out_ready from downstream
//   err_pulse             one cycle per dropped frame
//   err_count             saturating dropped-frame count

typedef struct packed {
  logic [31:0] ip;
  logic [15:0] port;
} endpoint_s;

typedef struct packed {
  logic [7:0] protocol;
  endpoint_s  src;
  endpoint_s  dst;
} packet_s;

module packet_header_parser #(
  parameter int HDR_BYTES = 13,  // field slicing below assumes 13
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output packet_s              out_packet,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int         ASM_W    = (HDR_BYTES - 1) * 8;
  localparam logic [3:0] LAST_IDX = 4'(HDR_BYTES - 1);

  typedef enum logic {COLLECT, DISCARD} state_e;

  state_e               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [ASM_W-1:0]     asm_q, asm_d;
  packet_s              pkt_q, pkt_d;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic    at_last;
  logic    accept;
  packet_s hdr;

  // The final byte can only land once the holding register is free (or
  // being drained this same cycle), so nothing is ever overwritten.
  assign at_last  = (idx_q == LAST_IDX);
  assign in_ready = (state_q == DISCARD) || !at_last || !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  // First 12 bytes sit MSB-first in asm_q; the protocol byte arrives live.
  always_comb begin
    hdr          = '0;
    hdr.src.ip   = asm_q[95:64];
    hdr.dst.ip   = asm_q[63:32];
    hdr.src.port = asm_q[31:16];
    hdr.dst.port = asm_q[15:0];
    hdr.protocol = in_data;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    pkt_d   = pkt_q;
    err_d   = 1'b0;
    vld_d   = vld_q && !out_ready;
    if (accept) begin
      case (state_q)
        COLLECT: begin
          if (at_last) begin
            idx_d = '0;
            if (in_last) begin
              pkt_d = hdr;
              vld_d = 1'b1;
            end else begin
              // Too long: flag once now, swallow the rest silently.
              state_d = DISCARD;
              err_d   = 1'b1;
            end
          end else begin
            asm_d = {asm_q[ASM_W-9:0], in_data};
            if (in_last) begin
              idx_d = '0;
              err_d = 1'b1;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        DISCARD: begin
          if (in_last) begin
            state_d = COLLECT;
            idx_d   = '0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
    cnt_d = (err_d && (cnt_q != '1)) ? cnt_q + ERR_CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      asm_q   <= '0;
      pkt_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      pkt_q   <= pkt_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_packet = pkt_q;
  assign out_valid  = vld_q;
  assign err_pulse  = err_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_packet_header_parser.sv
// Directed + randomized bench for packet_header_parser. The reference model
// builds expected headers straight from frame byte lists and frame lengths;
// a negedge monitor records delivered headers and error pulses.
module tb_packet_header_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid, err_pulse;
  packet_s     out_packet;
  logic [15:0] err_count;

  logic        in_ready2, out_valid2, err_pulse2;
  packet_s     out_packet2;
  logic [1:0]  err_count2;

  always #5 clk = ~clk;

  packet_header_parser dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_packet(out_packet),
    .out_valid(out_valid), .out_ready(out_ready), .err_pulse(err_pulse),
    .err_count(err_count)
  );

  packet_header_parser #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready2), .out_packet(out_packet2),
    .out_valid(out_valid2), .out_ready(out_ready), .err_pulse(err_pulse2),
    .err_count(err_count2)
  );

  packet_s    got_q[$];
  packet_s    exp_q[$];
  logic [7:0] frm[$];
  int n_vec = 0, n_err = 0, pulses = 0, exp_drops = 0, rd = 0;
  int exp_cnt = 0, exp_cnt2 = 0;
  bit rdy_rand = 1'b0, gaps = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got_q.push_back(out_packet);
      if (err_pulse) pulses++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit acc = 1'b0;
    in_valid = 1'b1; in_data = b; in_last = last;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    chk("byte accepted", acc, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
  endtask

  function automatic packet_s build_pkt();
    packet_s p;
    p.src.ip   = {frm[0], frm[1], frm[2], frm[3]};
    p.dst.ip   = {frm[4], frm[5], frm[6], frm[7]};
    p.src.port = {frm[8], frm[9]};
    p.dst.port = {frm[10], frm[11]};
    p.protocol = frm[12];
    return p;
  endfunction

  task automatic mk_frame(input int len);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
  endtask

  task automatic send_frame();
    foreach (frm[i]) send_byte(frm[i], i == frm.size() - 1);
    if (frm.size() == 13) exp_q.push_back(build_pkt());
    else begin
      exp_drops++;
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; rdy_rand = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_packet", out_packet, '0);
    chk("rst err_pulse", err_pulse, 1'b0);
    chk("rst err_count", err_count, '0);
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst w2 out_valid", out_valid2, 1'b0);
    chk("rst w2 out_packet", out_packet2, '0);
    chk("rst w2 in_ready", in_ready2, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0; exp_cnt2 = 0;
  endtask

  task automatic drain_check(input string tag);
    rdy_rand = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk({tag, " out count"}, got_q.size(), exp_q.size());
    while (rd < got_q.size() && rd < exp_q.size()) begin
      chk({tag, " header"}, got_q[rd], exp_q[rd]);
      rd++;
    end
    chk({tag, " drops"}, pulses, exp_drops);
    chk({tag, " err_count"}, err_count, exp_cnt);
    chk({tag, " err_count w2"}, err_count2, exp_cnt2);
  endtask

  initial begin
    packet_s pa, pb;
    int      seq[5] = '{1, 2, 3, 3, 3};
    int      r, len;

    do_reset();

    // 1: reference header, one-cycle latency
    out_ready = 1'b1;
    frm = '{8'hC0, 8'hA8, 8'h01, 8'h02, 8'h0A, 8'h00, 8'h00, 8'h01,
            8'h1F, 8'h90, 8'h00, 8'h50, 8'h06};
    for (int i = 0; i < 12; i++) send_byte(frm[i], 1'b0);
    chk("t1 no early valid", out_valid, 1'b0);
    send_byte(frm[12], 1'b1);
    chk("t1 latency", out_valid, 1'b1);
    chk("t1 src.ip", out_packet.src.ip, 32'hC0A80102);
    chk("t1 dst.ip", out_packet.dst.ip, 32'h0A000001);
    chk("t1 src.port", out_packet.src.port, 16'd8080);
    chk("t1 dst.port", out_packet.dst.port, 16'd80);
    chk("t1 protocol", out_packet.protocol, 8'd6);
    exp_q.push_back(build_pkt());
    tick();
    chk("t1 single beat", out_valid, 1'b0);
    drain_check("t1");

    // 2: back-pressure, back-to-back frames
    out_ready = 1'b0;
    mk_frame(13);
    send_frame();
    pa = build_pkt();
    chk("t2 A valid", out_valid, 1'b1);
    chk("t2 A header", out_packet, pa);
    mk_frame(13);
    pb = build_pkt();
    for (int i = 0; i < 12; i++) send_byte(frm[i], 1'b0);
    chk("t2 stall at last byte", in_ready, 1'b0);
    in_valid = 1'b1; in_data = frm[12]; in_last = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("t2 hold valid", out_valid, 1'b1);
      chk("t2 hold header", out_packet, pa);
    end
    chk("t2 still stalled", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("t2 ready on drain", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    exp_q.push_back(pb);
    chk("t2 drain+load valid", out_valid, 1'b1);
    chk("t2 B header", out_packet, pb);
    drain_check("t2");

    // 3: short frame then good frame
    mk_frame(5);
    send_frame();
    chk("t3 err_pulse", err_pulse, 1'b1);
    chk("t3 no output", out_valid, 1'b0);
    tick();
    chk("t3 pulse one cycle", err_pulse, 1'b0);
    mk_frame(13);
    send_frame();
    drain_check("t3");

    // 4: long frame then good frame
    do_reset();
    mk_frame(16);
    send_frame();
    chk("t4 no output", out_valid, 1'b0);
    chk("t4 err_count", err_count, 16'd1);
    mk_frame(13);
    send_frame();
    drain_check("t4");

    // 5: reset mid-frame
    out_ready = 1'b1;
    mk_frame(13);
    for (int i = 0; i < 7; i++) send_byte(frm[i], 1'b0);
    do_reset();
    out_ready = 1'b1;
    mk_frame(13);
    send_frame();
    drain_check("t5");

    // 6: saturation of a 2-bit counter
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mk_frame(3);
      send_frame();
      chk("t6 err_pulse", err_pulse2, 1'b1);
      chk("t6 err_count w2", err_count2, seq[i]);
      chk("t6 no output", out_valid2, 1'b0);
      chk("t6 err_count w16", err_count, exp_cnt);
    end
    drain_check("t6");

    // 7: random frames, gaps and back-pressure
    gaps = 1'b1; rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      r   = int'($urandom_range(0, 9));
      len = (r < 6) ? 13 : (r < 8) ? int'($urandom_range(1, 12)) : int'($urandom_range(14, 20));
      mk_frame(len);
      send_frame();
    end
    drain_check("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
